// File: rtl/bp_pkg.sv
// Shared types and constants for the tournament branch predictor.
// Record index fields are IDX_W wide, so LHT_BITS and GHR_BITS must stay below IDX_W.
package bp_pkg;

    localparam int IDX_W = 24;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_WEAK_TAKEN   = 2'b10;
    localparam ctr_t CTR_STRONG_LOCAL = 2'b00;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } bp_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] lidx;
        logic [IDX_W-1:0] gidx;
        logic             lpred;
        logic             gpred;
    } inflight_rec_t;

    function automatic ctr_t ctr_step(input ctr_t c, input logic up);
        ctr_t r;
        r = c;
        if (up && c != 2'b11) begin
            r = c + 2'b01;
        end else if (!up && c != 2'b00) begin
            r = c - 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Circular queue of unresolved predictions; the head record is visible combinationally.
// The parent guarantees push/pop legality, so push with pop on a full queue is safe.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  inflight_rec_t wdata,
    output inflight_rec_t rdata,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    inflight_rec_t        mem [DEPTH];
    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;
    logic [PW:0]          count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/param_tournament_branch_predictor.sv
// Tournament predictor: local and global 2-bit tables arbitrated by a per-PC chooser,
// trained non-speculatively from an in-order queue of in-flight predictions.
module param_tournament_branch_predictor
    import bp_pkg::*;
#(
    parameter int LHT_BITS       = 4,
    parameter int GHR_BITS       = 8,
    parameter int GSHARE         = 0,
    parameter int INFLIGHT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_branch_addr,
    input  logic [31:0] offset,
    input  logic        branch_decode_sig,
    input  logic        branch_mem_sig,
    input  logic        actual_branch_decision,
    output logic [31:0] out_branch_addr,
    output logic        prediction,
    output logic        selected_predictor,
    output logic        ready,
    output logic        inflight_full,
    output logic        overflow_err,
    output logic        underflow_err
);

    localparam int SWEEP_BITS = (LHT_BITS > GHR_BITS) ? LHT_BITS : GHR_BITS;
    localparam int LSIZE      = 1 << LHT_BITS;
    localparam int GSIZE      = 1 << GHR_BITS;

    ctr_t local_tbl   [LSIZE];
    ctr_t global_tbl  [GSIZE];
    ctr_t chooser_tbl [LSIZE];

    bp_state_t             state;
    bp_state_t             state_next;
    logic [SWEEP_BITS-1:0] sweep;
    logic [GHR_BITS-1:0]   ghr;

    logic [LHT_BITS-1:0] lidx;
    logic [GHR_BITS-1:0] gidx;
    logic                lpred;
    logic                gpred;
    logic                run;
    logic                push_ok;
    logic                pop_ok;
    logic                fifo_full;
    logic                fifo_empty;
    inflight_rec_t       push_rec;
    inflight_rec_t       head;
    logic [LHT_BITS-1:0] h_lidx;
    logic [GHR_BITS-1:0] h_gidx;
    logic                unused_head_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            sweep <= '0;
        end else begin
            state <= state_next;
            sweep <= (state == ST_INIT) ? sweep + SWEEP_BITS'(1) : '0;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_INIT && sweep == '1) begin
            state_next = ST_RUN;
        end
    end

    assign run   = (state == ST_RUN);
    assign ready = run;

    assign lidx  = pc_branch_addr[LHT_BITS-1:0];
    assign gidx  = (GSHARE != 0) ? (ghr ^ pc_branch_addr[GHR_BITS-1:0]) : ghr;
    assign lpred = local_tbl[lidx][1];
    assign gpred = global_tbl[gidx][1];

    assign out_branch_addr    = pc_branch_addr + offset;
    assign selected_predictor = chooser_tbl[lidx][1];
    assign prediction         = run & (selected_predictor ? gpred : lpred);

    // A pop frees a slot in the same edge, so push is accepted on a full queue if a pop is legal.
    assign pop_ok  = run & branch_mem_sig & ~fifo_empty;
    assign push_ok = run & branch_decode_sig & (~fifo_full | pop_ok);

    assign push_rec.lidx  = IDX_W'(lidx);
    assign push_rec.gidx  = IDX_W'(gidx);
    assign push_rec.lpred = lpred;
    assign push_rec.gpred = gpred;

    assign h_lidx         = head.lidx[LHT_BITS-1:0];
    assign h_gidx         = head.gidx[GHR_BITS-1:0];
    assign unused_head_hi = ^{head.lidx[IDX_W-1:LHT_BITS], head.gidx[IDX_W-1:GHR_BITS]};

    bp_inflight_fifo #(
        .DEPTH (INFLIGHT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop_ok),
        .wdata (push_rec),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inflight_full = fifo_full;

    // Tables carry no reset; the INIT sweep rewrites every entry, shorter tables skip out-of-range steps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                if ((sweep >> LHT_BITS) == '0) begin
                    local_tbl[sweep[LHT_BITS-1:0]]   <= CTR_WEAK_TAKEN;
                    chooser_tbl[sweep[LHT_BITS-1:0]] <= CTR_STRONG_LOCAL;
                end
                if ((sweep >> GHR_BITS) == '0) begin
                    global_tbl[sweep[GHR_BITS-1:0]] <= CTR_WEAK_TAKEN;
                end
            end else if (pop_ok) begin
                local_tbl[h_lidx]  <= ctr_step(local_tbl[h_lidx], actual_branch_decision);
                global_tbl[h_gidx] <= ctr_step(global_tbl[h_gidx], actual_branch_decision);
                if (head.lpred != head.gpred) begin
                    chooser_tbl[h_lidx] <= ctr_step(chooser_tbl[h_lidx],
                                                    head.gpred == actual_branch_decision);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr           <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (run) begin
            if (pop_ok) ghr <= {ghr[GHR_BITS-2:0], actual_branch_decision};
            if (branch_decode_sig && !push_ok) overflow_err <= 1'b1;
            if (branch_mem_sig && fifo_empty) underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_param_tournament_branch_predictor.sv
// Directed plus random stimulus against a behavioural predictor model; expected outputs
// are queued at drive time and popped when the outputs are sampled.
module tb_param_tournament_branch_predictor;

    localparam int LHT   = 4;
    localparam int GHR   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_branch_addr;
    logic [31:0] offset;
    logic        branch_decode_sig;
    logic        branch_mem_sig;
    logic        actual_branch_decision;
    logic [31:0] out_branch_addr;
    logic        prediction;
    logic        selected_predictor;
    logic        ready;
    logic        inflight_full;
    logic        overflow_err;
    logic        underflow_err;

    always #5 clk = ~clk;

    param_tournament_branch_predictor #(
        .LHT_BITS       (LHT),
        .GHR_BITS       (GHR),
        .GSHARE         (0),
        .INFLIGHT_DEPTH (DEPTH)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .pc_branch_addr         (pc_branch_addr),
        .offset                 (offset),
        .branch_decode_sig      (branch_decode_sig),
        .branch_mem_sig         (branch_mem_sig),
        .actual_branch_decision (actual_branch_decision),
        .out_branch_addr        (out_branch_addr),
        .prediction             (prediction),
        .selected_predictor     (selected_predictor),
        .ready                  (ready),
        .inflight_full          (inflight_full),
        .overflow_err           (overflow_err),
        .underflow_err          (underflow_err)
    );

    typedef struct {
        int lidx;
        int gidx;
        bit lp;
        bit gp;
    } mrec_t;

    typedef struct {
        logic        pred;
        logic        sel;
        logic [31:0] addr;
        logic        rdy;
        logic        full;
        logic        ovf;
        logic        udf;
    } exp_t;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int    m_local   [1 << LHT];
    int    m_global  [1 << GHR];
    int    m_chooser [1 << LHT];
    int    m_ghr;
    bit    m_run;
    bit    m_ovf;
    bit    m_udf;
    mrec_t m_q [$];
    exp_t  sb  [$];

    function automatic int sat(input int c, input bit up);
        if (up)  return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_run = 0;
        m_ghr = 0;
        m_ovf = 0;
        m_udf = 0;
        m_q.delete();
        sb.delete();
    endtask

    task automatic modelInitTables();
        for (int i = 0; i < (1 << LHT); i++) begin
            m_local[i]   = 2;
            m_chooser[i] = 0;
        end
        for (int i = 0; i < (1 << GHR); i++) m_global[i] = 2;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".pred"}, 32'(prediction), 32'(e.pred));
        if (e.rdy) chk({tag, ".sel"}, 32'(selected_predictor), 32'(e.sel));
        chk({tag, ".addr"}, out_branch_addr, e.addr);
        chk({tag, ".ready"}, 32'(ready), 32'(e.rdy));
        chk({tag, ".full"}, 32'(inflight_full), 32'(e.full));
        chk({tag, ".ovf"}, 32'(overflow_err), 32'(e.ovf));
        chk({tag, ".udf"}, 32'(underflow_err), 32'(e.udf));
    endtask

    // One cycle: drive, predict from the model's pre-edge state, sample, then advance the model.
    task automatic applyStimulus(input string tag, input bit dec, input bit mem, input bit act,
                                 input logic [31:0] pc, input logic [31:0] off);
        exp_t  e;
        mrec_t cur;
        mrec_t r;
        bit    pop;
        bit    push;
        branch_decode_sig      = dec;
        branch_mem_sig         = mem;
        actual_branch_decision = act;
        pc_branch_addr         = pc;
        offset                 = off;
        cur.lidx = int'(pc[LHT-1:0]);
        cur.gidx = m_ghr;
        cur.lp   = (m_local[cur.lidx] >= 2);
        cur.gp   = (m_global[cur.gidx] >= 2);
        e.sel    = (m_chooser[cur.lidx] >= 2);
        e.pred   = m_run ? (e.sel ? cur.gp : cur.lp) : 1'b0;
        e.addr   = pc + off;
        e.rdy    = m_run;
        e.full   = (m_q.size() == DEPTH);
        e.ovf    = m_ovf;
        e.udf    = m_udf;
        sb.push_back(e);
        #3;
        checkOutput(tag);
        if (m_run) begin
            pop  = mem && (m_q.size() > 0);
            push = dec && ((m_q.size() < DEPTH) || pop);
            if (dec && !push) m_ovf = 1;
            if (mem && m_q.size() == 0) m_udf = 1;
            if (pop) begin
                r = m_q.pop_front();
                m_local[r.lidx]  = sat(m_local[r.lidx], act);
                m_global[r.gidx] = sat(m_global[r.gidx], act);
                if (r.lp != r.gp) m_chooser[r.lidx] = sat(m_chooser[r.lidx], r.gp == act);
                m_ghr = ((m_ghr << 1) | int'(act)) & ((1 << GHR) - 1);
            end
            if (push) m_q.push_back(cur);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        reset             = 1'b1;
        branch_decode_sig = 1'b0;
        branch_mem_sig    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        chk({tag, ".ready"}, 32'(ready), 32'd0);
        chk({tag, ".full"}, 32'(inflight_full), 32'd0);
        chk({tag, ".ovf"}, 32'(overflow_err), 32'd0);
        chk({tag, ".udf"}, 32'(underflow_err), 32'd0);
    endtask

    task automatic waitReady(input string tag);
        int cyc;
        cyc = 0;
        while (!ready && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".init_cycles"}, 32'(cyc), 32'd256);
        modelInitTables();
        m_run = 1;
    endtask

    initial begin
        reset                  = 1'b1;
        pc_branch_addr         = '0;
        offset                 = '0;
        branch_decode_sig      = 1'b0;
        branch_mem_sig         = 1'b0;
        actual_branch_decision = 1'b0;
        modelInitTables();
        modelReset();
        @(posedge clk);
        #1;

        doReset("rst0");
        waitReady("init0");

        // Train pc0 towards global: NT, NT at pc0, T at pc1, T, T at pc0.
        applyStimulus("d0a", 1, 0, 0, 32'd0, 32'd0);
        applyStimulus("r0a", 0, 1, 0, 32'd0, 32'd0);
        applyStimulus("d0b", 1, 0, 0, 32'd0, 32'd0);
        applyStimulus("r0b", 0, 1, 0, 32'd0, 32'd0);
        applyStimulus("d1",  1, 0, 0, 32'd1, 32'd0);
        applyStimulus("r1",  0, 1, 1, 32'd1, 32'd0);
        applyStimulus("d0c", 1, 0, 0, 32'd0, 32'd0);
        applyStimulus("r0c", 0, 1, 1, 32'd0, 32'd0);
        applyStimulus("d0d", 1, 0, 0, 32'd0, 32'd0);
        applyStimulus("r0d", 0, 1, 1, 32'd0, 32'd0);
        pc_branch_addr    = 32'd0;
        branch_decode_sig = 1'b0;
        branch_mem_sig    = 1'b0;
        #2;
        chk("trained.sel", 32'(selected_predictor), 32'd1);
        chk("trained.pred", 32'(prediction), 32'd1);

        applyStimulus("addr_small", 0, 0, 0, 32'd3, 32'd7);
        applyStimulus("addr_large", 0, 0, 0, 32'd0, 32'h00FF_FFFF);
        applyStimulus("addr_wrap",  0, 0, 0, 32'hFFFF_FFF0, 32'h0000_0020);

        for (int i = 0; i < 24; i++) begin
            applyStimulus($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 15)), $urandom);
        end
        for (int i = 0; i < DEPTH + 1 && m_q.size() > 0; i++) begin
            applyStimulus($sformatf("drain%0d", i), 0, 1, 1'($urandom_range(0, 1)), 32'd0, 32'd0);
        end
        applyStimulus("udf_pop", 0, 1, 1, 32'd0, 32'd0);
        for (int p = 0; p < 4; p++) begin
            applyStimulus($sformatf("after_udf_pc%0d", p), 0, 0, 0, 32'(p), 32'd4);
        end

        doReset("rst1");
        waitReady("init1");
        for (int p = 0; p < DEPTH; p++) begin
            applyStimulus($sformatf("fill%0d", p), 1, 0, 0, 32'(p), 32'd0);
        end
        applyStimulus("full_push_pop", 1, 1, 1, 32'd5, 32'd0);
        chk("full_push_pop.still_full", 32'(inflight_full), 32'd1);
        chk("full_push_pop.no_ovf", 32'(overflow_err), 32'd0);
        applyStimulus("full_push", 1, 0, 0, 32'd6, 32'd0);
        chk("full_push.ovf", 32'(overflow_err), 32'd1);
        applyStimulus("idle_after_ovf", 0, 0, 0, 32'd0, 32'd0);

        doReset("rst2");
        waitReady("init2");
        applyStimulus("inflight_a", 1, 0, 0, 32'd2, 32'd0);
        applyStimulus("inflight_b", 1, 0, 0, 32'd3, 32'd0);
        doReset("rst_run");
        waitReady("init3");
        applyStimulus("post_rst_pop", 0, 1, 1, 32'd0, 32'd0);
        chk("post_rst_pop.udf", 32'(underflow_err), 32'd1);
        applyStimulus("post_rst_pc0", 1, 0, 0, 32'd0, 32'd0);
        applyStimulus("post_rst_idle", 0, 0, 0, 32'd0, 32'd0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/param_tournament_branch_predictor.md
PARAM_TOURNAMENT_BRANCH_PREDICTOR -- requirements
Module: param_tournament_branch_predictor

Interface
REQ-001 Parameter LHT_BITS, 4: index width of the local and chooser tables; index = pc[LHT_BITS-1:0].
REQ-002 Parameter GHR_BITS, 8: global history length and global table index width.
REQ-003 Parameter GSHARE, 0: 0 = global index is GHR; 1 = GHR XOR pc[GHR_BITS-1:0].
REQ-004 Parameter INFLIGHT_DEPTH, 4: number of unresolved predictions held; power of two, at least 2.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pc_branch_addr  in  32  PC of the branch in decode.
REQ-008 offset  in  32  branch offset.
REQ-009 branch_decode_sig  in  1  branch in decode; request prediction and push a record.
REQ-010 branch_mem_sig  in  1  oldest branch resolved; pop a record and update.
REQ-011 actual_branch_decision  in  1  resolved direction, valid with branch_mem_sig.
REQ-012 out_branch_addr  out  32  pc_branch_addr + offset, mod 2^32.
REQ-013 prediction  out  1  predicted direction.
REQ-014 selected_predictor  out  1  0 = local, 1 = global.
REQ-015 ready  out  1  tables initialised.
REQ-016 inflight_full  out  1  queue holds INFLIGHT_DEPTH records.
REQ-017 overflow_err  out  1  sticky flag: push dropped.
REQ-018 underflow_err  out  1  sticky flag: pop of an empty queue.

Function
REQ-019 Tables shall be 2-bit saturating counters: local[2^LHT_BITS], global[2^GHR_BITS], chooser[2^LHT_BITS].
REQ-020 out_branch_addr, prediction and selected_predictor shall be combinational from current inputs and state, with zero latency.
REQ-021 selected_predictor shall be chooser[idx][1]; prediction shall be the MSB of the selected counter, and 0 while ready=0.
REQ-022 On a decode in RUN state, the block shall push {local idx, global idx, local pred, global pred} when not full.
REQ-023 On a pop in RUN state, the block shall update local[rec idx] and global[rec gidx] toward actual_branch_decision, saturating at 00 and 11.
REQ-024 On a pop, the block shall update chooser[rec idx] only when the local and global predictions differ: +1 if global was correct, -1 if local was correct, saturating.
REQ-025 On a pop, GHR shall become {GHR[GHR_BITS-2:0], actual_branch_decision}; GHR is non-speculative.
REQ-026 A decode in the same cycle as an update to the same entry shall read the pre-update value (no bypass).
REQ-027 A simultaneous push and pop shall always be accepted, including when the queue is full; occupancy is unchanged.
REQ-028 A push when full without a pop shall be dropped and set overflow_err; prediction outputs still drive normally.
REQ-029 A pop when empty shall leave tables and GHR unchanged and set underflow_err.
REQ-030 FSM states: INIT and RUN. INIT sweeps counter i from 0 to 2^max(LHT_BITS,GHR_BITS)-1, one entry per cycle, writing local=10, global=10 and chooser=00 for every in-range i, then enters RUN.
REQ-031 In INIT, decode and mem signals shall be ignored and no error flag shall be set.

Reset
REQ-032 Reset shall force: state=INIT, sweep counter=0, GHR=0, queue empty, ready=0, inflight_full=0, overflow_err=0, underflow_err=0.
REQ-033 Reset asserted during RUN shall discard all in-flight records and re-run the full INIT sweep.

Structure
REQ-034 Shared package bp_pkg shall hold the counter type, the counter reset constants (10, 00), the INIT/RUN state enum and the in-flight record type.
REQ-035 The in-flight queue shall be the sub-module bp_inflight_fifo.

Verification (defaults: LHT_BITS=4, GHR_BITS=8, GSHARE=0, INFLIGHT_DEPTH=4)
REQ-036 Release reset -> ready rises after 256 cycles; decode at pc=0 -> prediction=1, selected_predictor=0.
REQ-037 pc=3, offset=7 -> out_branch_addr=10; pc=0, offset=0xFFFFFF -> out_branch_addr=0xFFFFFF.
REQ-038 pc0 not-taken x2, pc1 taken, then pc0 taken x2 (each a decode then a resolve) -> chooser[0]=10; next decode at pc0 -> selected_predictor=1, prediction=1 (global[7]=10).
REQ-039 4 decodes with no resolves -> inflight_full=1; 5th decode -> overflow_err=1; 5th decode with a simultaneous pop -> accepted, no error.
REQ-040 branch_mem_sig with the queue empty -> underflow_err=1; GHR and tables unchanged.
REQ-041 Reset asserted with 2 records in flight -> ready=0 next cycle, queue empty; after 256 cycles decode at pc=0 -> prediction=1.
